// File: rtl/pipeline_run_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pipeline_run_ctrl_pkg                                            |
// | Purpose : Shared command codes and FSM state encoding for the pipeline     |
// |           run controller. The debug unit also imports these.              |
// | Contents: CMD_NOP/RUN/STEP/STOP, state_e (ST_IDLE..ST_HALTED, 3 bits),     |
// |           cmd_ready() decode helper.                                       |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package pipeline_run_ctrl_pkg;

  localparam int ST_W = 3;

  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_STOP = 2'b11;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_STEP   = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_HALTED = 3'd4
  } state_e;

  // Commands are accepted in every state except the two where the pipe is
  // committed to a fixed number of enabled cycles (STEP, DRAIN).
  function automatic logic cmd_ready(input state_e s);
    return (s == ST_IDLE) || (s == ST_RUN) || (s == ST_HALTED);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_run_ctrl_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pipeline_run_ctrl_sat_counter                                    |
// | Purpose : Saturating up-counter (sat_counter) with synchronous clear.      |
// |           Holds at all-ones instead of wrapping.                           |
// | Ports   : i_clock, i_reset (sync, active-high), i_clr, i_inc,              |
// |           o_count[WIDTH-1:0]                                               |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module pipeline_run_ctrl_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_clr) begin
      count_d = '0;
    end else if (i_inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule
`default_nettype wire

// File: rtl/pipeline_run_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pipeline_run_ctrl                                                |
// | Purpose : Sequences the global pipeline enable from RUN/STEP/STOP debug    |
// |           commands, drains the pipe after HLT leaves EX/MEM, then parks.   |
// |           Keeps a saturating count of enabled cycles.                      |
// | Ports   : i_clock, i_reset (sync, active-high), i_cmd_valid, i_cmd[1:0],   |
// |           o_cmd_ready, i_mem_hlt, o_pipeline_enable, o_busy, o_halted,     |
// |           o_done, o_timeout, o_cycle_count[NB_CYCLE-1:0], o_state[2:0]     |
// | Config  : PIPE_CTRL_WATCHDOG_EN enables the RUN-length watchdog            |
// |           (WDOG_LIMIT); without it o_timeout is constant 0.                |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module pipeline_run_ctrl
  import pipeline_run_ctrl_pkg::*;
#(
  parameter int NB_CYCLE     = 32,
  parameter int DRAIN_CYCLES = 2,
  parameter int WDOG_LIMIT   = 2**20
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_cmd_valid,
  input  logic [1:0]          i_cmd,
  output logic                o_cmd_ready,
  input  logic                i_mem_hlt,
  output logic                o_pipeline_enable,
  output logic                o_busy,
  output logic                o_halted,
  output logic                o_done,
  output logic                o_timeout,
  output logic [NB_CYCLE-1:0] o_cycle_count,
  output logic [ST_W-1:0]     o_state
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_e             state_q, state_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               enable_q, enable_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  logic               cmd_acc;
  logic               wdog_expired;

  assign o_cmd_ready = cmd_ready(state_q);
  assign cmd_acc     = i_cmd_valid && o_cmd_ready;

`ifdef PIPE_CTRL_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_LIMIT + 1);

  logic [WDOG_W-1:0] wdog_count;
  logic              wdog_clr;
  logic              wdog_inc;

  // Counter holds the number of RUN cycles already completed, so the cycle in
  // which it reads LIMIT-1 is the LIMIT-th enabled RUN cycle.
  assign wdog_clr     = (state_q != ST_RUN) && (state_d == ST_RUN);
  assign wdog_inc     = (state_q == ST_RUN);
  assign wdog_expired = (state_q == ST_RUN) && (wdog_count == WDOG_W'(WDOG_LIMIT - 1));

  pipeline_run_ctrl_sat_counter #(
    .WIDTH (WDOG_W)
  ) u_wdog (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clr   (wdog_clr),
    .i_inc   (wdog_inc),
    .o_count (wdog_count)
  );
`else
  assign wdog_expired = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    enable_d  = enable_q;
    timeout_d = timeout_q;

    case (state_q)
      ST_IDLE: begin
        enable_d = 1'b0;
        if (cmd_acc && (i_cmd == CMD_RUN)) begin
          state_d  = ST_RUN;
          enable_d = 1'b1;
        end else if (cmd_acc && (i_cmd == CMD_STEP)) begin
          state_d  = ST_STEP;
          enable_d = 1'b1;
        end
      end

      ST_RUN: begin
        enable_d = 1'b1;
        // HLT beats both the watchdog and a coincident STOP: the halting
        // instruction must still retire.
        if (i_mem_hlt) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_W'(DRAIN_CYCLES - 1);
        end else if (wdog_expired) begin
          state_d   = ST_HALTED;
          enable_d  = 1'b0;
          timeout_d = 1'b1;
        end else if (cmd_acc && (i_cmd == CMD_STOP)) begin
          state_d  = ST_IDLE;
          enable_d = 1'b0;
        end
      end

      ST_STEP: begin
        if (i_mem_hlt) begin
          state_d  = ST_DRAIN;
          drain_d  = DRAIN_W'(DRAIN_CYCLES - 1);
          enable_d = 1'b1;
        end else begin
          state_d  = ST_IDLE;
          enable_d = 1'b0;
        end
      end

      ST_DRAIN: begin
        enable_d = 1'b1;
        if (drain_q == '0) begin
          state_d  = ST_HALTED;
          enable_d = 1'b0;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end

      ST_HALTED: begin
        enable_d = 1'b0;
      end

      default: begin
        state_d  = ST_IDLE;
        enable_d = 1'b0;
      end
    endcase

    done_d = (state_d == ST_HALTED) && (state_q != ST_HALTED);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      drain_q   <= '0;
      enable_q  <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      enable_q  <= enable_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  // Counts edges at which the registered enable was high.
  pipeline_run_ctrl_sat_counter #(
    .WIDTH (NB_CYCLE)
  ) u_cycle_count (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clr   (1'b0),
    .i_inc   (enable_q),
    .o_count (o_cycle_count)
  );

  assign o_pipeline_enable = enable_q;
  assign o_done            = done_q;
  assign o_timeout         = timeout_q;
  assign o_busy            = (state_q == ST_RUN) || (state_q == ST_STEP) || (state_q == ST_DRAIN);
  assign o_halted          = (state_q == ST_HALTED);
  assign o_state           = state_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_run_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_pipeline_run_ctrl                                             |
// | Purpose : Self-checking bench for pipeline_run_ctrl: directed scenarios    |
// |           with literal expectations plus randomized traffic compared each  |
// |           cycle against a behavioural model. Honors PIPE_CTRL_WATCHDOG_EN. |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_pipeline_run_ctrl;

  localparam int NB   = 8;
  localparam int DC   = 2;
  localparam int WL   = 16;
  localparam int CMAX = (1 << NB) - 1;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          valid = 1'b0;
  logic [1:0]    cmd   = 2'b00;
  logic          hlt   = 1'b0;
  logic          ready, en, busy, halted, done, tmo;
  logic [NB-1:0] cnt;
  logic [2:0]    st;

  pipeline_run_ctrl #(
    .NB_CYCLE     (NB),
    .DRAIN_CYCLES (DC),
    .WDOG_LIMIT   (WL)
  ) dut (
    .i_clock           (clk),
    .i_reset           (rst),
    .i_cmd_valid       (valid),
    .i_cmd             (cmd),
    .o_cmd_ready       (ready),
    .i_mem_hlt         (hlt),
    .o_pipeline_enable (en),
    .o_busy            (busy),
    .o_halted          (halted),
    .o_done            (done),
    .o_timeout         (tmo),
    .o_cycle_count     (cnt),
    .o_state           (st)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

`ifdef PIPE_CTRL_WATCHDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model. Modes: 0 idle, 1 running, 2 single step,
  // 3 draining, 4 parked. Counts are plain integers.
  int m_mode, m_en, m_cnt, m_done, m_tmo, m_left, m_runlen;

  always @(posedge clk) begin : model
    bit acc;
    if (rst) begin
      m_mode = 0; m_en = 0; m_cnt = 0; m_done = 0; m_tmo = 0; m_left = 0; m_runlen = 0;
    end else begin
      if (m_en != 0 && m_cnt < CMAX) m_cnt = m_cnt + 1;
      m_done = 0;
      acc = valid && (m_mode == 0 || m_mode == 1 || m_mode == 4);
      case (m_mode)
        0: begin
          if (acc && cmd == 2'b01) begin m_mode = 1; m_en = 1; m_runlen = 0; end
          else if (acc && cmd == 2'b10) begin m_mode = 2; m_en = 1; end
        end
        1: begin
          m_runlen = m_runlen + 1;
          if (hlt) begin m_mode = 3; m_left = DC - 1; end
          else if (WDOG && m_runlen >= WL) begin m_mode = 4; m_en = 0; m_tmo = 1; m_done = 1; end
          else if (acc && cmd == 2'b11) begin m_mode = 0; m_en = 0; end
        end
        2: begin
          if (hlt) begin m_mode = 3; m_left = DC - 1; end
          else begin m_mode = 0; m_en = 0; end
        end
        3: begin
          if (m_left == 0) begin m_mode = 4; m_en = 0; m_done = 1; end
          else m_left = m_left - 1;
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("state",   st,     m_mode);
      chk("enable",  en,     m_en);
      chk("count",   cnt,    m_cnt);
      chk("done",    done,   m_done);
      chk("timeout", tmo,    m_tmo);
      chk("ready",   ready,  (m_mode == 0 || m_mode == 1 || m_mode == 4));
      chk("busy",    busy,   (m_mode >= 1 && m_mode <= 3));
      chk("halted",  halted, (m_mode == 4));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c);
    valid = 1'b1;
    cmd   = c;
    tick();
    valid = 1'b0;
    cmd   = 2'b00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  initial begin
    tick();
    chk_on = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("reset_state", st, 0);
    chk("reset_ready", ready, 1);
    chk("reset_count", cnt, 0);

    // Single steps, one rejected while stepping.
    send(2'b10);
    chk("step_en", en, 1);
    chk("step_ready", ready, 0);
    send(2'b10);
    chk("step_en_off", en, 0);
    send(2'b10);
    tick();
    send(2'b10);
    tick();
    tick();
    chk("step_count", cnt, 3);
    chk("step_idle", st, 0);

    // RUN for 10 then STOP, RUN for 5 more.
    do_reset();
    send(2'b01);
    repeat (9) tick();
    send(2'b11);
    chk("run10_count", cnt, 10);
    chk("run10_idle", st, 0);
    send(2'b01);
    repeat (4) tick();
    send(2'b11);
    chk("run15_count", cnt, 15);

    // HLT seen at the 7th RUN edge, two drain cycles follow.
    do_reset();
    send(2'b01);
    repeat (6) tick();
    hlt = 1'b1;
    tick();
    hlt = 1'b0;
    chk("drain_state", st, 3);
    tick();
    tick();
    chk("halt_done", done, 1);
    chk("halt_count", cnt, 9);
    chk("halt_en", en, 0);
    tick();
    chk("halt_done_clr", done, 0);
    send(2'b01);
    chk("halt_stays", st, 4);

    // STOP and HLT together.
    do_reset();
    send(2'b01);
    repeat (3) tick();
    valid = 1'b1; cmd = 2'b11; hlt = 1'b1;
    tick();
    valid = 1'b0; cmd = 2'b00; hlt = 1'b0;
    chk("simul_drain", st, 3);
    tick();
    tick();
    chk("simul_halted", halted, 1);

    // Reset held mid-RUN.
    do_reset();
    send(2'b01);
    repeat (5) tick();
    do_reset();
    chk("midrst_state", st, 0);
    chk("midrst_en", en, 0);
    chk("midrst_count", cnt, 0);
    chk("midrst_ready", ready, 1);

    // Long RUN without HLT.
    send(2'b01);
    repeat (100) tick();
`ifdef PIPE_CTRL_WATCHDOG_EN
    chk("wdog_halted", st, 4);
    chk("wdog_timeout", tmo, 1);
    chk("wdog_count", cnt, 16);
`else
    chk("long_run", st, 1);
    chk("long_count", cnt, 100);
    repeat (200) tick();
    chk("sat_count", cnt, CMAX);
`endif

    // Randomized traffic, checked by the model every cycle.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(0, 149) == 0);
      valid = $urandom_range(0, 1) == 1;
      cmd   = 2'($urandom_range(0, 3));
      hlt   = ($urandom_range(0, 24) == 0);
      tick();
    end
    rst = 1'b0; valid = 1'b0; hlt = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
